fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a word-aligned PC through instruction
// memory, buffers {pc, instr} pairs in a 2-entry queue toward decode, and
// handles redirects (flush + retarget) and end-of-program halting.
module fetch_controller #(
   parameter int unsigned MEM_SIZE = 16,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [63:0] imem_adr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        halted,
   output logic        misalign_err
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

   // First byte address past the end of the program image.
   localparam logic [63:0] PC_LIMIT = 64'(MEM_SIZE) * 64'd4;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [63:0] head_pc_q, head_pc_d;
   logic [31:0] head_instr_q, head_instr_d;
   logic [63:0] tail_pc_q, tail_pc_d;
   logic [31:0] tail_instr_q, tail_instr_d;
   logic        misalign_q, misalign_d;

   logic        redir_fetch;
   logic        redir_aligned;
   logic        in_range;
   logic        head_valid;
   logic        pop;
   logic        push;
   logic [1:0]  slot;

   // Handshake qualifiers shared by next-state and datapath logic.
   always_comb begin
      redir_fetch   = (state_q == S_FETCH) && redirect_valid;
      redir_aligned = (redirect_pc[1:0] == 2'b00);
      in_range      = (pc_q < PC_LIMIT);
      head_valid    = (count_q != 2'd0) && !redir_fetch;
      pop           = head_valid && out_ready;
      push          = (state_q == S_FETCH) && !redirect_valid && in_range &&
                      ((count_q < 2'd2) || pop);
      // Queue slot the new entry lands in, after any head pop shifts it down.
      slot          = count_q - {1'b0, pop};
   end

   // State and datapath registers; the whole block clears asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         count_q      <= 2'd0;
         head_pc_q    <= 64'd0;
         head_instr_q <= 32'd0;
         tail_pc_q    <= 64'd0;
         tail_instr_q <= 32'd0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         count_q      <= count_d;
         head_pc_q    <= head_pc_d;
         head_instr_q <= head_instr_d;
         tail_pc_q    <= tail_pc_d;
         tail_instr_q <= tail_instr_d;
         misalign_q   <= misalign_d;
      end
   end

   // Next-state: HALT is terminal until reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (redirect_valid) begin
               if (!redir_aligned) state_d = S_HALT;
            end else if (!in_range) begin
               state_d = S_HALT;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // PC, queue and sticky-error updates; a FETCH redirect overrides the queue.
   always_comb begin
      pc_d         = pc_q;
      count_d      = count_q + {1'b0, push} - {1'b0, pop};
      head_pc_d    = head_pc_q;
      head_instr_d = head_instr_q;
      tail_pc_d    = tail_pc_q;
      tail_instr_d = tail_instr_q;
      misalign_d   = misalign_q;

      if (pop) begin
         head_pc_d    = tail_pc_q;
         head_instr_d = tail_instr_q;
      end
      if (push) begin
         pc_d = pc_q + 64'd4;
         if (slot == 2'd0) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_instr;
         end else begin
            tail_pc_d    = pc_q;
            tail_instr_d = imem_instr;
         end
      end

      if (redir_fetch) begin
         count_d = 2'd0;
         if (redir_aligned) pc_d = redirect_pc;
         else               misalign_d = 1'b1;
      end else if ((state_q == S_IDLE) && redirect_valid && redir_aligned) begin
         pc_d = redirect_pc;
      end
   end

   // Outputs: memory address tracks the PC; the consumer sees the queue head.
   always_comb begin
      imem_adr     = pc_q;
      out_valid    = head_valid;
      out_instr    = head_instr_q;
      out_pc       = head_pc_q;
      halted       = (state_q == S_HALT);
      misalign_err = misalign_q;
   end

endmodule
